m_icache_fetch: RTL and testbench

Instruction-fetch front end placed between the IF-stage PC register and the multi-cycle instruction memory (request on re, one-cycle oe response pulse).
- Direct-mapped instruction cache with combinational hit path.
- Miss FSM that issues one memory request, waits for the response, refills the line and forwards the word.
- Stall output freezes the PC and IF/ID registers while a miss is outstanding.

---
 rtl/m_icache_fetch.sv | 157 +++++++++++++++
 tb/tb_m_icache_fetch.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_icache_fetch.sv
// m_icache_fetch: direct-mapped, one-word-line instruction cache with a single-outstanding miss FSM.
// Define ICACHE_PERF_EN to add the r_hit_cnt / r_miss_cnt performance counters.
module m_icache_fetch #(
    parameter int IDX_W      = 5,
    parameter bit INIT_VALID = 1'b0
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic [31:0] w_pc,
    input  logic        w_req,
    input  logic        w_flush,
    output logic [31:0] w_insn,
    output logic        w_valid,
    output logic        w_stall,
    output logic        w_mem_re,
    output logic [31:0] w_mem_adr,
    input  logic [31:0] w_mem_insn,
    input  logic        w_mem_oe
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] r_hit_cnt,
    output logic [31:0] r_miss_cnt
`endif
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_FILL = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         state_next;
    logic [31:0]        r_pc;
    logic [31:0]        r_data;
    logic [ENTRIES-1:0] valid_reg;
    logic [ENTRIES-1:0] fill_sel;
    logic [TAG_W-1:0]   tag_mem  [ENTRIES];
    logic [31:0]        data_mem [ENTRIES];

    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic               hit;
    logic               idle_miss;
    logic               fill_we;
    logic               pc_match;

    assign idx       = w_pc[IDX_W+1:2];
    assign pc_tag    = w_pc[31:IDX_W+2];
    assign fill_idx  = r_pc[IDX_W+1:2];
    assign hit       = valid_reg[idx] && (tag_mem[idx] == pc_tag);
    assign idle_miss = (r_state == ST_IDLE) && w_req && !hit;
    assign fill_we   = (r_state == ST_FILL);
    assign pc_match  = (w_pc[31:2] == r_pc[31:2]);

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_fill_sel
            assign fill_sel[gi] = fill_we && (fill_idx == IDX_W'(gi));
        end
    endgenerate

    // Flush beats a same-cycle refill, so the forwarded word never becomes a stale line.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            valid_reg <= {ENTRIES{INIT_VALID}};
        end else if (w_flush) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_reg | fill_sel;
        end
    end

    always_ff @(posedge w_clk) begin
        if (fill_we) begin
            tag_mem[fill_idx]  <= r_pc[31:IDX_W+2];
            data_mem[fill_idx] <= r_data;
        end
    end

    always_comb begin
        state_next = r_state;
        case (r_state)
            ST_IDLE: if (idle_miss) state_next = ST_REQ;
            ST_REQ:  state_next = ST_WAIT;
            ST_WAIT: if (w_mem_oe) state_next = ST_FILL;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_data  <= '0;
        end else begin
            r_state <= state_next;
            if (idle_miss) begin
                r_pc <= w_pc;
            end
            if ((r_state == ST_WAIT) && w_mem_oe) begin
                r_data <= w_mem_insn;
            end
        end
    end

    // Outputs are forced quiet while reset is held, even with w_req asserted.
    always_comb begin
        w_valid   = 1'b0;
        w_stall   = 1'b0;
        w_mem_re  = 1'b0;
        w_insn    = r_data;
        w_mem_adr = r_pc;
        if (!w_rst) begin
            case (r_state)
                ST_IDLE: begin
                    w_insn  = data_mem[idx];
                    w_valid = w_req && hit;
                    w_stall = w_req && !hit;
                end
                ST_REQ: begin
                    w_mem_re  = 1'b1;
                    w_stall   = 1'b1;
                    w_mem_adr = {r_pc[31:2], 2'b00};
                end
                ST_WAIT: begin
                    w_stall = 1'b1;
                end
                default: begin
                    w_valid = w_req && pc_match;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_EN
    logic idle_hit;
    assign idle_hit = (r_state == ST_IDLE) && w_req && hit;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (idle_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (idle_miss) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_m_icache_fetch.sv
// tb_m_icache_fetch: directed and randomized fetch transactions checked against a line-address cache model.
module tb_m_icache_fetch;
    logic        w_clk;
    logic        w_rst;
    logic [31:0] w_pc;
    logic        w_req;
    logic        w_flush;
    logic [31:0] w_insn;
    logic        w_valid;
    logic        w_stall;
    logic        w_mem_re;
    logic [31:0] w_mem_adr;
    logic [31:0] w_mem_insn;
    logic        w_mem_oe;
`ifdef ICACHE_PERF_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Model: which word address (pc[31:2]) each of the 32 lines currently holds.
    bit          m_present [32];
    logic [29:0] m_line    [32];
    int          m_hits    = 0;
    int          m_misses  = 0;

    m_icache_fetch #(.IDX_W(5), .INIT_VALID(1'b0)) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .w_pc       (w_pc),
        .w_req      (w_req),
        .w_flush    (w_flush),
        .w_insn     (w_insn),
        .w_valid    (w_valid),
        .w_stall    (w_stall),
        .w_mem_re   (w_mem_re),
        .w_mem_adr  (w_mem_adr),
        .w_mem_insn (w_mem_insn),
        .w_mem_oe   (w_mem_oe)
`ifdef ICACHE_PERF_EN
        ,
        .r_hit_cnt  (r_hit_cnt),
        .r_miss_cnt (r_miss_cnt)
`endif
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] adr);
        logic [31:0] a;
        a = {adr[31:2], 2'b00};
        if (a == 32'h40) return 32'h00500093;
        return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[6:2]);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return m_present[idx_of(pc)] && (m_line[idx_of(pc)] == pc[31:2]);
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] hi;
        int          t;
        t  = int'($urandom_range(0, 3));
        hi = (t == 3) ? 32'hFFFF_FF80 : (32'(t) << 7);
        return hi | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_present[i] = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic chk_perf();
`ifdef ICACHE_PERF_EN
        chk("hit_cnt", r_hit_cnt, 32'(m_hits));
        chk("miss_cnt", r_miss_cnt, 32'(m_misses));
`endif
    endtask

    task automatic idle_cycle(input bit flush);
        w_req   = 1'b0;
        w_flush = flush;
        w_pc    = rand_pc();
        @(negedge w_clk);
        chk("noreq_valid", 32'(w_valid), 32'd0);
        chk("noreq_stall", 32'(w_stall), 32'd0);
        chk("noreq_re", 32'(w_mem_re), 32'd0);
        tick();
        w_flush = 1'b0;
        if (flush) model_clear();
        $display("idle flush=%0d", flush);
    endtask

    // One fetch transaction: a hit in a single cycle, or a full miss with memory delay d (>=1).
    task automatic fetch(input logic [31:0] pc, input int d, input bit flush_idle,
                         input bit flush_wait, input bit flush_fill, input logic [31:0] fill_pc);
        bit hit;
        bit fwd;
        hit     = model_hit(pc);
        w_req   = 1'b1;
        w_pc    = pc;
        w_flush = flush_idle;
        @(negedge w_clk);
        chk("idle_valid", 32'(w_valid), 32'(hit));
        chk("idle_stall", 32'(w_stall), 32'(!hit));
        chk("idle_re", 32'(w_mem_re), 32'd0);
        if (hit) chk("hit_insn", w_insn, mem_word(pc));
        tick();
        w_flush = 1'b0;
        if (flush_idle) model_clear();
        if (hit) begin
            m_hits++;
            $display("fetch pc=%h hit", pc);
            return;
        end
        m_misses++;
        @(negedge w_clk);
        chk("req_re", 32'(w_mem_re), 32'd1);
        chk("req_adr", w_mem_adr, {pc[31:2], 2'b00});
        chk("req_stall", 32'(w_stall), 32'd1);
        chk("req_valid", 32'(w_valid), 32'd0);
        tick();
        for (int k = 1; k <= d; k++) begin
            if (k == 1) w_flush = flush_wait;
            if (k == d) begin
                w_mem_oe   = 1'b1;
                w_mem_insn = mem_word(pc);
            end
            @(negedge w_clk);
            chk("wait_stall", 32'(w_stall), 32'd1);
            chk("wait_re", 32'(w_mem_re), 32'd0);
            chk("wait_valid", 32'(w_valid), 32'd0);
            chk("wait_adr", w_mem_adr, pc);
            tick();
            w_flush    = 1'b0;
            w_mem_oe   = 1'b0;
            w_mem_insn = 32'h0;
        end
        if (flush_wait) model_clear();
        fwd     = (fill_pc[31:2] == pc[31:2]);
        w_pc    = fill_pc;
        w_flush = flush_fill;
        @(negedge w_clk);
        chk("fill_stall", 32'(w_stall), 32'd0);
        chk("fill_valid", 32'(w_valid), 32'(fwd));
        chk("fill_re", 32'(w_mem_re), 32'd0);
        if (fwd) chk("fill_insn", w_insn, mem_word(pc));
        tick();
        w_flush = 1'b0;
        if (flush_fill) begin
            model_clear();
        end else begin
            m_present[idx_of(pc)] = 1'b1;
            m_line[idx_of(pc)]    = pc[31:2];
        end
        $display("fetch pc=%h miss d=%0d fwd=%0d flush=%0d%0d%0d", pc, d, fwd,
                 flush_idle, flush_wait, flush_fill);
    endtask

    initial begin
        w_rst      = 1'b0;
        w_req      = 1'b0;
        w_pc       = 32'h0;
        w_flush    = 1'b0;
        w_mem_insn = 32'h0;
        w_mem_oe   = 1'b0;
        model_clear();
        #1;
        w_rst = 1'b1;
        w_req = 1'b1;
        w_pc  = 32'h40;
        #2;
        chk("rst_valid", 32'(w_valid), 32'd0);
        chk("rst_stall", 32'(w_stall), 32'd0);
        chk("rst_re", 32'(w_mem_re), 32'd0);
        chk("rst_adr", w_mem_adr, 32'h0);
        tick();
        tick();
        w_rst = 1'b0;
        w_req = 1'b0;
        chk_perf();

        // Cold miss, then hits on the same and a neighbouring line.
        fetch(32'h40, 3, 0, 0, 0, 32'h40);
        fetch(32'h40, 1, 0, 0, 0, 32'h40);
        fetch(32'h44, 2, 0, 0, 0, 32'h44);
        fetch(32'h40, 1, 0, 0, 0, 32'h40);
        fetch(32'h44, 1, 0, 0, 0, 32'h44);
        fetch(32'h40, 1, 0, 0, 0, 32'h40);
        chk_perf();

        // Index conflict: 0xC0 evicts 0x40.
        fetch(32'hC0, 1, 0, 0, 0, 32'hC0);
        fetch(32'h40, 2, 0, 0, 0, 32'h40);

        // Flush in IDLE keeps the same-cycle hit; flush in FILL keeps the line invalid.
        fetch(32'h40, 1, 1, 0, 0, 32'h40);
        fetch(32'h40, 2, 0, 0, 1, 32'h40);
        fetch(32'h40, 1, 0, 0, 0, 32'h40);

        // Redirect during a miss: no forward, but the line is still installed.
        idle_cycle(1'b1);
        fetch(32'h40, 3, 0, 0, 0, 32'h80);
        fetch(32'h80, 2, 0, 0, 0, 32'h80);
        fetch(32'h40, 1, 0, 0, 0, 32'h40);
        chk_perf();

        // Reset while waiting for memory, then a stale response.
        idle_cycle(1'b1);
        w_req = 1'b1;
        w_pc  = 32'h40;
        @(negedge w_clk);
        chk("rm_stall", 32'(w_stall), 32'd1);
        tick();
        @(negedge w_clk);
        chk("rm_re", 32'(w_mem_re), 32'd1);
        tick();
        @(negedge w_clk);
        chk("rm_wait", 32'(w_stall), 32'd1);
        tick();
        w_rst = 1'b1;
        #2;
        chk("rm_rst_stall", 32'(w_stall), 32'd0);
        chk("rm_rst_valid", 32'(w_valid), 32'd0);
        chk("rm_rst_adr", w_mem_adr, 32'h0);
        model_clear();
        m_hits   = 0;
        m_misses = 0;
        tick();
        w_rst      = 1'b0;
        w_req      = 1'b0;
        w_mem_oe   = 1'b1;
        w_mem_insn = 32'hDEADBEEF;
        @(negedge w_clk);
        chk("stale_valid", 32'(w_valid), 32'd0);
        chk("stale_stall", 32'(w_stall), 32'd0);
        tick();
        w_mem_oe   = 1'b0;
        w_mem_insn = 32'h0;
        $display("reset mid-miss with stale response");
        fetch(32'h40, 1, 0, 0, 0, 32'h40);
        chk_perf();

        // Randomized traffic over a small aliasing address pool.
        for (int n = 0; n < 250; n++) begin
            logic [31:0] pc;
            logic [31:0] fpc;
            pc  = rand_pc();
            fpc = ($urandom_range(0, 99) < 15) ? rand_pc() : pc;
            if ($urandom_range(0, 99) < 10) begin
                idle_cycle($urandom_range(0, 99) < 30);
            end else begin
                fetch(pc, int'($urandom_range(1, 4)), $urandom_range(0, 99) < 5,
                      $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 8, fpc);
            end
        end
        chk_perf();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
